uart_hex_frame_gen: RTL and testbench
=====================================

Name: uart_hex_frame_gen

Overview:
Parametrised telemetry framer that turns NUM_CH sampled channels of DATA_W bits into an ASCII hex line, e.g. "<1234|ABCD|00F0>\n". It sits between sensor/sample producers and the uart_tx byte FIFO, replacing hand-built per-channel message indexing. Frame emission is triggered by a start strobe (from strobe_gen). Output is a valid/ready byte stream with full back-pressure support.

Parameters:
NUM_CH, 3, number of channels (1..16)
DATA_W, 16, bits per channel (1..64); DIGITS = ceil(DATA_W/4) hex digits per channel
SEP_CHAR, "|", separator byte between channels

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  sample-write strobe
in_data  in  NUM_CH*DATA_W  channel k at bits [k*DATA_W +: DATA_W]; channel 0 is emitted first
start  in  1  frame request pulse
o_tvalid  out  1  byte valid
o_tdata  out  8  ASCII byte
i_tready  in  1  downstream accepts byte
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse when the '\n' byte is accepted
overrun  out  1  one-cycle pulse when start arrives while busy

Behaviour:
- Reset values: o_tvalid=0, o_tdata=0, busy=0, frame_done=0, overrun=0. sample_r=0. stale=1. FSM=IDLE. All counters are 0.
- Sample register: in_valid loads sample_r from in_data and clears stale. It is accepted in any state.
- Start in IDLE:
  - Snapshot sample_r into frame_r. If in_valid is high in the same cycle, snapshot in_data instead.
  - Latch the stale flag, then set stale=1.
  - busy rises the next cycle.
- Start while busy: ignored; overrun pulses. The current frame continues unchanged.
- FSM states: IDLE -> SOF -> DIGIT -> (SEP -> DIGIT)* -> EOF -> NL -> IDLE.
  - SOF byte is '<', or '!' if the latched stale flag was 1.
  - DIGIT emits DIGITS bytes per channel, MSB nibble first.
  - SEP is emitted between channels only; never after the last channel.
  - EOF byte is '>'. NL byte is 0x0A.
- Hex encoding: uppercase '0'-'9', 'A'-'F'. If DATA_W is not a multiple of 4, the top nibble is zero-padded.
- Frame length: 3 + NUM_CH*DIGITS + (NUM_CH-1) bytes.
- Handshake:
  - A byte transfers on o_tvalid && i_tready.
  - While o_tvalid=1 and i_tready=0, o_tdata holds stable.
  - o_tvalid never drops without a transfer (except on reset).
- Timing:
  - First byte is presented the cycle after start.
  - Consecutive bytes are back-to-back when i_tready=1 (one byte per clock).
- Counters: channel counter 0..NUM_CH-1 and digit counter DIGITS-1..0, both wrap within a frame.
- On NL transfer: frame_done=1, busy=0, FSM=IDLE. A start in the cycle after the NL transfer is accepted.
- Reset mid-frame: output drops immediately (o_tvalid=0); the partial frame is abandoned and not resumed.

Optional Feature:
FRAME_CHECKSUM_EN
- Defined:
  - After the last channel's digits, emit '*' followed by two uppercase hex digits, then '>' and '\n'.
  - Checksum = XOR of all frame bytes from SOF through the last data digit inclusive; '*' is excluded.
  - Frame length grows by 3.
- Undefined: no checksum logic or states are present; frame is exactly as above.

Test Plan:
1. NUM_CH=3, DATA_W=16, i_tready=1. in_valid with x=0x1234, y=0xABCD, z=0x00F0, then start -> "<1234|ABCD|00F0>\n". 17 consecutive bytes, frame_done on byte 17, busy for 17 cycles.
2. Same stimulus, i_tready toggles 1,0,0,1 repeating -> identical byte sequence. o_tdata is stable during every stall; no byte is duplicated or dropped.
3. Start pulsed 5 cycles into a frame -> overrun is a single pulse; output is still exactly one 17-byte frame.
4. Two starts with no in_valid between them -> second frame begins with '!'. in_valid and start in the same cycle with x=0xFFFF -> frame begins "<FFFF".
5. Assert rst at byte 6 of a frame -> o_tvalid=0 the same cycle. After release, a start produces "!0000|0000|0000>\n".
6. FRAME_CHECKSUM_EN defined, stimulus as in test 1 -> "<1234|ABCD|00F0*4A>\n", 20 bytes. Also NUM_CH=1, DATA_W=10, data 0x3FF -> "<3FF>\n".

Source files
------------

// File: rtl/uart_hex_frame_gen.sv
// uart_hex_frame_gen: turns NUM_CH sampled channels into an ASCII hex line
// such as "<1234|ABCD|00F0>\n" and streams it out one byte per transfer.
// Optional build macro FRAME_CHECKSUM_EN appends "*HH" (XOR of SOF through
// the last data digit) before the closing '>'.
//
// Output handshake: a byte moves when o_tvalid && i_tready are both high on
// a rising clk edge. Once o_tvalid is high it stays high, and o_tdata stays
// unchanged, until that transfer happens (only rst can withdraw it).
module uart_hex_frame_gen #(
    parameter int         NUM_CH   = 3,
    parameter int         DATA_W   = 16,
    parameter logic [7:0] SEP_CHAR = "|"
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic                     start,
    output logic                     o_tvalid,
    output logic [7:0]               o_tdata,
    input  logic                     i_tready,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     overrun
);
    localparam int DIGITS = (DATA_W + 3) / 4;
    localparam int PAD_W  = DIGITS * 4;
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DG_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
    localparam logic [DG_W-1:0] TOP_DG  = DG_W'(DIGITS - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SOF,
        S_DIGIT,
        S_SEP,
`ifdef FRAME_CHECKSUM_EN
        S_STAR,
        S_CK_HI,
        S_CK_LO,
`endif
        S_EOF,
        S_NL
    } state_t;

    state_t                     state, state_nx;
    logic [NUM_CH*DATA_W-1:0]   sample_r;
    logic [NUM_CH*DATA_W-1:0]   frame_r;
    logic                       stale;
    logic                       stale_l;
    logic [CH_W-1:0]            ch_cnt;
    logic [DG_W-1:0]            dg_cnt;
    logic [DATA_W-1:0]          ch_sel;
    logic [PAD_W-1:0]           ch_pad;
    logic [3:0]                 nibble;
    logic                       start_acc;
    logic                       xfer;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]                 csum;
`endif

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        hex_ascii = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign start_acc = start && (state == S_IDLE);
    assign xfer      = o_tvalid && i_tready;

    // Sample register, frame snapshot and staleness tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_r <= '0;
            frame_r  <= '0;
            stale    <= 1'b1;
            stale_l  <= 1'b0;
        end else begin
            if (in_valid) sample_r <= in_data;
            if (start_acc) begin
                // A same-cycle in_valid supplies fresh data straight into the frame.
                frame_r <= in_valid ? in_data : sample_r;
                stale_l <= stale && !in_valid;
                stale   <= 1'b1;
            end else if (in_valid) begin
                stale   <= 1'b0;
            end
        end
    end

    // Channel and digit counters walk the snapshot during DIGIT transfers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_cnt <= '0;
            dg_cnt <= '0;
        end else if (start_acc) begin
            ch_cnt <= '0;
            dg_cnt <= TOP_DG;
        end else if (xfer && state == S_DIGIT) begin
            if (dg_cnt == '0) begin
                dg_cnt <= TOP_DG;
                ch_cnt <= (ch_cnt == LAST_CH) ? '0 : ch_cnt + CH_W'(1);
            end else begin
                dg_cnt <= dg_cnt - DG_W'(1);
            end
        end
    end

`ifdef FRAME_CHECKSUM_EN
    // Running XOR over SOF, digits and separators as they are accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum <= '0;
        end else if (xfer) begin
            if (state == S_SOF)
                csum <= o_tdata;
            else if (state == S_DIGIT || state == S_SEP)
                csum <= csum ^ o_tdata;
        end
    end
`endif

    // Pick the current channel out of the snapshot.
    always_comb begin
        ch_sel = '0;
        for (int k = 0; k < NUM_CH; k++)
            if (ch_cnt == CH_W'(k)) ch_sel = frame_r[k*DATA_W +: DATA_W];
    end

    assign ch_pad = PAD_W'(ch_sel);

    // Pick the current nibble; the top nibble is zero-padded when needed.
    always_comb begin
        nibble = '0;
        for (int d = 0; d < DIGITS; d++)
            if (dg_cnt == DG_W'(d)) nibble = ch_pad[d*4 +: 4];
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // FSM next state and byte/status outputs.
    always_comb begin
        state_nx   = state;
        o_tvalid   = (state != S_IDLE);
        busy       = (state != S_IDLE);
        frame_done = (state == S_NL) && i_tready;
        overrun    = start && (state != S_IDLE);
        o_tdata    = 8'h00;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_SOF;
            end
            S_SOF: begin
                o_tdata = stale_l ? 8'h21 : 8'h3C;
                if (i_tready) state_nx = S_DIGIT;
            end
            S_DIGIT: begin
                o_tdata = hex_ascii(nibble);
                if (i_tready && dg_cnt == '0) begin
`ifdef FRAME_CHECKSUM_EN
                    state_nx = (ch_cnt == LAST_CH) ? S_STAR : S_SEP;
`else
                    state_nx = (ch_cnt == LAST_CH) ? S_EOF : S_SEP;
`endif
                end
            end
            S_SEP: begin
                o_tdata = SEP_CHAR;
                if (i_tready) state_nx = S_DIGIT;
            end
`ifdef FRAME_CHECKSUM_EN
            S_STAR: begin
                o_tdata = 8'h2A;
                if (i_tready) state_nx = S_CK_HI;
            end
            S_CK_HI: begin
                o_tdata = hex_ascii(csum[7:4]);
                if (i_tready) state_nx = S_CK_LO;
            end
            S_CK_LO: begin
                o_tdata = hex_ascii(csum[3:0]);
                if (i_tready) state_nx = S_EOF;
            end
`endif
            S_EOF: begin
                o_tdata = 8'h3E;
                if (i_tready) state_nx = S_NL;
            end
            S_NL: begin
                o_tdata = 8'h0A;
                if (i_tready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_hex_frame_gen.sv
// Self-checking bench for uart_hex_frame_gen (3x16 instance plus a 1x10
// instance for nibble padding). Honours FRAME_CHECKSUM_EN the same way.
module tb_uart_hex_frame_gen;
    localparam int NUM_CH = 3;
    localparam int DATA_W = 16;
`ifdef FRAME_CHECKSUM_EN
    localparam int FLEN = 20;
    localparam string LIT = "<1234|ABCD|00F0*4A>\n";
`else
    localparam int FLEN = 17;
    localparam string LIT = "<1234|ABCD|00F0>\n";
`endif
    localparam logic [47:0] LIT_DATA = {16'h00F0, 16'hABCD, 16'h1234};

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                     in_valid, start, i_tready;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic                     o_tvalid, busy, frame_done, overrun;
    logic [7:0]               o_tdata;

    logic       v2_in_valid, v2_start, v2_i_tready;
    logic [9:0] v2_in_data;
    logic       v2_o_tvalid, v2_busy, v2_frame_done, v2_overrun;
    logic [7:0] v2_o_tdata;

    uart_hex_frame_gen #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .start(start), .o_tvalid(o_tvalid), .o_tdata(o_tdata),
        .i_tready(i_tready), .busy(busy), .frame_done(frame_done),
        .overrun(overrun)
    );

    uart_hex_frame_gen #(.NUM_CH(1), .DATA_W(10)) dut2 (
        .clk(clk), .rst(rst), .in_valid(v2_in_valid), .in_data(v2_in_data),
        .start(v2_start), .o_tvalid(v2_o_tvalid), .o_tdata(v2_o_tdata),
        .i_tready(v2_i_tready), .busy(v2_busy), .frame_done(v2_frame_done),
        .overrun(v2_overrun)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    string      hexs = "0123456789ABCDEF";

    int          busy_cycles, overrun_pulses, done_pulses, done_byte, done_cyc, stall_bad;
    logic        first_valid, start_busy, prev_stall;
    logic [7:0]  prev_data;
    logic [47:0] cur_data;

    function automatic logic [7:0] hex_ch(input int n);
        return 8'(hexs[n]);
    endfunction

    // Reference model: the frame text from the data words and stale flag.
    function automatic void build_frame(input int nch, input int dw,
                                        input logic [255:0] data, input bit stale_f);
        logic [255:0] mask, v;
        logic [7:0]   ck;
        int           dig;
        dig  = (dw + 3) / 4;
        mask = (256'(1) << dw) - 256'(1);
        exp_q.delete();
        exp_q.push_back(stale_f ? 8'h21 : 8'h3C);
        for (int k = 0; k < nch; k++) begin
            v = (data >> (k * dw)) & mask;
            for (int d = dig - 1; d >= 0; d--)
                exp_q.push_back(hex_ch(int'((v >> (4 * d)) & 256'd15)));
            if (k < nch - 1) exp_q.push_back(8'h7C);
        end
`ifdef FRAME_CHECKSUM_EN
        ck = 8'h00;
        foreach (exp_q[i]) ck = ck ^ exp_q[i];
        exp_q.push_back(8'h2A);
        exp_q.push_back(hex_ch(int'(ck[7:4])));
        exp_q.push_back(hex_ch(int'(ck[3:0])));
`else
        ck = 8'h00;
`endif
        exp_q.push_back(8'h3E);
        exp_q.push_back(8'h0A);
    endfunction

    // driver tasks
    task automatic load(input logic [47:0] d);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = d;
        cur_data = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_start(input logic with_valid, input logic [47:0] d);
        @(posedge clk); #1;
        in_valid = with_valid;
        if (with_valid) begin
            in_data  = d;
            cur_data = d;
        end
        start = 1'b1;
        @(negedge clk);
        start_busy = busy;
    endtask

    // Runs max_cyc cycles after the start cycle with a tready pattern
    // (0: always, 1: 1,0,0,1 repeating, other: random), optionally pulsing
    // start again at cycle ovr_at; records accepted bytes and status.
    task automatic collect(input int mode, input int max_cyc, input int ovr_at);
        got_q.delete();
        busy_cycles = 0; overrun_pulses = 0; done_pulses = 0;
        done_byte = -1; done_cyc = -1; stall_bad = 0; prev_stall = 1'b0;
        first_valid = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk); #1;
            start    = (i == ovr_at);
            in_valid = 1'b0;
            case (mode)
                0:       i_tready = 1'b1;
                1:       i_tready = ((i % 4) == 0) || ((i % 4) == 3);
                default: i_tready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (i == 0) first_valid = o_tvalid;
            if (busy) busy_cycles++;
            if (overrun) overrun_pulses++;
            if (prev_stall && (!o_tvalid || o_tdata !== prev_data)) stall_bad++;
            if (o_tvalid && i_tready) got_q.push_back(o_tdata);
            if (frame_done) begin
                done_pulses++;
                done_byte = got_q.size();
                done_cyc  = i;
            end
            prev_stall = o_tvalid && !i_tready;
            prev_data  = o_tdata;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_checks++; if (o_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid got=%b exp=0", o_tvalid); end
        n_checks++; if (o_tdata !== 8'h00) begin n_fail++; $display("FAIL reset_tdata got=%h exp=00", o_tdata); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", frame_done); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    endtask

    task automatic test_basic;
        load(LIT_DATA);
        send_start(1'b0, '0);
        n_checks++; if (start_busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_start got=%b exp=0", start_busy); end
        collect(0, FLEN + 8, -1);
        n_checks++; if (got_q.size() != LIT.len()) begin n_fail++; $display("FAIL basic_len got=%0d exp=%0d", got_q.size(), LIT.len()); end
        for (int i = 0; i < LIT.len() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== 8'(LIT[i])) begin n_fail++; $display("FAIL basic_byte[%0d] got=%h exp=%h", i, got_q[i], 8'(LIT[i])); end
        end
        n_checks++; if (first_valid !== 1'b1) begin n_fail++; $display("FAIL basic_first_valid got=%b exp=1", first_valid); end
        n_checks++; if (done_pulses != 1) begin n_fail++; $display("FAIL basic_done_pulses got=%0d exp=1", done_pulses); end
        n_checks++; if (done_byte != FLEN) begin n_fail++; $display("FAIL basic_done_byte got=%0d exp=%0d", done_byte, FLEN); end
        n_checks++; if (done_cyc != FLEN - 1) begin n_fail++; $display("FAIL basic_done_cycle got=%0d exp=%0d", done_cyc, FLEN - 1); end
        n_checks++; if (busy_cycles != FLEN) begin n_fail++; $display("FAIL basic_busy_cycles got=%0d exp=%0d", busy_cycles, FLEN); end
    endtask

    task automatic test_backpressure;
        load(LIT_DATA);
        send_start(1'b0, '0);
        collect(1, 4 * FLEN, -1);
        n_checks++; if (got_q.size() != LIT.len()) begin n_fail++; $display("FAIL bp_len got=%0d exp=%0d", got_q.size(), LIT.len()); end
        for (int i = 0; i < LIT.len() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== 8'(LIT[i])) begin n_fail++; $display("FAIL bp_byte[%0d] got=%h exp=%h", i, got_q[i], 8'(LIT[i])); end
        end
        n_checks++; if (stall_bad != 0) begin n_fail++; $display("FAIL bp_stall_stable got=%0d exp=0", stall_bad); end
        n_checks++; if (done_pulses != 1) begin n_fail++; $display("FAIL bp_done_pulses got=%0d exp=1", done_pulses); end
    endtask

    task automatic test_overrun;
        load(LIT_DATA);
        send_start(1'b0, '0);
        collect(0, FLEN + 10, 4);
        n_checks++; if (overrun_pulses != 1) begin n_fail++; $display("FAIL ovr_pulses got=%0d exp=1", overrun_pulses); end
        n_checks++; if (got_q.size() != LIT.len()) begin n_fail++; $display("FAIL ovr_len got=%0d exp=%0d", got_q.size(), LIT.len()); end
        for (int i = 0; i < LIT.len() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== 8'(LIT[i])) begin n_fail++; $display("FAIL ovr_byte[%0d] got=%h exp=%h", i, got_q[i], 8'(LIT[i])); end
        end
    endtask

    task automatic test_stale;
        logic [47:0] d;
        send_start(1'b0, '0);
        collect(0, FLEN + 4, -1);
        build_frame(NUM_CH, DATA_W, 256'(cur_data), 1'b1);
        n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL stale_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stale_byte[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        d = {32'($urandom), 16'hFFFF};
        send_start(1'b1, d);
        collect(0, FLEN + 4, -1);
        build_frame(NUM_CH, DATA_W, 256'(d), 1'b0);
        n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL samecyc_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL samecyc_byte[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid;
        load({16'($urandom), 32'($urandom)});
        send_start(1'b0, '0);
        collect(0, 5, -1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_checks++; if (o_tvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_tvalid got=%b exp=0", o_tvalid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        @(posedge clk); #1;
        rst = 1'b0;
        cur_data = '0;
        @(negedge clk);
        n_checks++; if (o_tvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_resume got=%b exp=0", o_tvalid); end
        send_start(1'b0, '0);
        collect(0, FLEN + 4, -1);
        build_frame(NUM_CH, DATA_W, 256'(0), 1'b1);
        n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rstmid_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rstmid_byte[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_narrow;
        int dones;
        got_q.delete();
        dones = 0;
        @(posedge clk); #1;
        v2_in_valid = 1'b1; v2_in_data = 10'h3FF; v2_i_tready = 1'b1;
        @(posedge clk); #1;
        v2_in_valid = 1'b0; v2_start = 1'b1;
        @(posedge clk); #1;
        v2_start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (v2_o_tvalid && v2_i_tready) got_q.push_back(v2_o_tdata);
            if (v2_frame_done) dones++;
        end
        build_frame(1, 10, 256'h3FF, 1'b0);
        n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL narrow_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL narrow_byte[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        n_checks++; if (dones != 1) begin n_fail++; $display("FAIL narrow_done got=%0d exp=1", dones); end
    endtask

    task automatic test_random;
        int          r;
        bit          stale_f;
        logic [47:0] d;
        for (int f = 0; f < 20; f++) begin
            r = $urandom_range(0, 2);
            d = {16'($urandom), 32'($urandom)};
            if (r == 0) begin
                load(d);
                send_start(1'b0, '0);
                stale_f = 1'b0;
            end else if (r == 1) begin
                send_start(1'b1, d);
                stale_f = 1'b0;
            end else begin
                send_start(1'b0, '0);
                stale_f = 1'b1;
            end
            collect(2, 140, -1);
            build_frame(NUM_CH, DATA_W, 256'(cur_data), stale_f);
            n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand%0d_len got=%0d exp=%0d", f, got_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_byte[%0d] got=%h exp=%h", f, i, got_q[i], exp_q[i]); end
            end
            n_checks++; if (stall_bad != 0) begin n_fail++; $display("FAIL rand%0d_stall got=%0d exp=0", f, stall_bad); end
            n_checks++; if (done_pulses != 1) begin n_fail++; $display("FAIL rand%0d_done got=%0d exp=1", f, done_pulses); end
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; start = 1'b0; i_tready = 1'b0;
        v2_in_valid = 1'b0; v2_in_data = '0; v2_start = 1'b0; v2_i_tready = 1'b0;
        cur_data = '0;
        repeat (3) @(posedge clk);
        test_reset;
        @(posedge clk); #1;
        rst = 1'b0;
        test_basic;
        test_backpressure;
        test_overrun;
        test_stale;
        test_reset_mid;
        test_narrow;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
